jtopl_wrseq: RTL and testbench

Write sequencer that sits between a host or sound-driver core and the OPL register interface (the `write`/`addr`/`din` port of the memory-mapped register block).
- Buffers (register, value) pairs in a small FIFO.
- Replays each pair as an address write followed by a data write.
- Enforces chip-accurate settling waits, counted in `cenop` ticks, after each write, so software can push pairs back-to-back without polling.

---
 rtl/jtopl_pkg.sv | 39 +++
 rtl/jtopl_wrseq_fifo.sv | 81 ++++++++
 rtl/jtopl_wrseq.sv | 114 +++++++++++
 tb/tb_jtopl_wrseq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// Shared types and timing constants for the OPL write sequencer.
// The FSM encoding, the queued entry layout and the chip settling
// times live here so the FIFO and the sequencer agree on them.
package jtopl_pkg;

   // Sequencer states: one strobe state per half of a pair, each
   // followed by its own settling wait.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_WAIT_A = 3'd2,
      ST_DATA   = 3'd3,
      ST_WAIT_D = 3'd4
   } wrseq_state_t;

   // Settling waits in cenop ticks. OPL and OPL2 share the same figures,
   // but they are kept separate so a different chip can diverge later.
   localparam int OPL_WAIT_ADDR  = 12;
   localparam int OPL_WAIT_DATA  = 84;
   localparam int OPL2_WAIT_ADDR = 12;
   localparam int OPL2_WAIT_DATA = 84;

   // One queued register write: register number first, value second.
   typedef struct packed {
      logic [7:0] regn;
      logic [7:0] val;
   } wrseq_entry_t;

   // Picks the address-write wait for the selected chip family.
   function automatic int default_wait_addr(input bit opl2);
      return opl2 ? OPL2_WAIT_ADDR : OPL_WAIT_ADDR;
   endfunction

   // Picks the data-write wait for the selected chip family.
   function automatic int default_wait_data(input bit opl2);
      return opl2 ? OPL2_WAIT_DATA : OPL_WAIT_DATA;
   endfunction

endpackage

// File: rtl/jtopl_wrseq_fifo.sv
// Small synchronous FIFO of (register, value) pairs feeding the write
// sequencer. Flags are registered from the next-state count so they are
// glitch free; a push into a full FIFO is dropped and latched in ovf.
module jtopl_wrseq_fifo
   import jtopl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  wrseq_entry_t din,
   input  logic         pop,
   output wrseq_entry_t head,
   output logic         full,
   output logic         empty,
   output logic         ovf,
   output logic         empty_nxt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   wrseq_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic [CNTW-1:0] count_nxt;
   logic            push_ok;
   logic            pop_ok;

   // A full FIFO refuses the push even when a pop frees a slot in the
   // same clock, because full is the registered view of the count.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + CNTW'(1);
         2'b01:   count_nxt = count - CNTW'(1);
         default: count_nxt = count;
      endcase
      empty_nxt = (count_nxt == '0);
   end

   // Entry storage; contents need no reset since the flags guard reads.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && full) begin
            ovf <= 1'b1;
         end
         count <= count_nxt;
         full  <= (count_nxt == CNTW'(DEPTH));
         empty <= empty_nxt;
      end
   end

endmodule

// File: rtl/jtopl_wrseq.sv
// Write sequencer between a host and the OPL register block. Queued pairs
// are replayed as an address write then a data write, each followed by the
// chip's settling time counted in cenop ticks, so the host never polls.
module jtopl_wrseq
   import jtopl_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int WAIT_ADDR = default_wait_addr(1'b0),
   parameter int WAIT_DATA = default_wait_data(1'b0),
   parameter int CW        = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cenop,
   input  logic       push,
   input  logic [7:0] push_reg,
   input  logic [7:0] push_val,
   output logic       full,
   output logic       empty,
   output logic       ovf,
   output logic       busy,
   output logic       wr,
   output logic       wr_addr,
   output logic [7:0] wr_din
);

   wrseq_state_t  state;
   logic [CW-1:0] cnt;
   wrseq_entry_t  push_entry;
   wrseq_entry_t  head;
   logic          pop;
   logic          fifo_empty_nxt;

   assign push_entry = {push_reg, push_val};

   // The head entry is retired during the data strobe, so the next pair
   // is already at the head when the data wait expires.
   assign pop = (state == ST_DATA);

   jtopl_wrseq_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .din       (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .ovf       (ovf),
      .empty_nxt (fifo_empty_nxt)
   );

   // Sequencer FSM. Strobe outputs are loaded together with the move into
   // ADDR or DATA so wr is high exactly while the FSM sits in those states.
   // busy is loaded with the value (next state != IDLE) | !next_empty so
   // it tracks the combined FSM/FIFO activity without a combinational path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         wr      <= 1'b0;
         wr_addr <= 1'b0;
         wr_din  <= 8'h00;
         busy    <= 1'b0;
      end else begin
         wr   <= 1'b0;
         busy <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state   <= ST_ADDR;
                  wr      <= 1'b1;
                  wr_addr <= 1'b0;
                  wr_din  <= head.regn;
               end else begin
                  busy <= !fifo_empty_nxt;
               end
            end
            ST_ADDR: begin
               cnt   <= CW'(WAIT_ADDR);
               state <= ST_WAIT_A;
            end
            ST_WAIT_A: begin
               if (cnt == '0) begin
                  state   <= ST_DATA;
                  wr      <= 1'b1;
                  wr_addr <= 1'b1;
                  wr_din  <= head.val;
               end else if (cenop) begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DATA: begin
               cnt   <= CW'(WAIT_DATA);
               state <= ST_WAIT_D;
            end
            ST_WAIT_D: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= !fifo_empty_nxt;
               end else if (cenop) begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Self-checking bench for jtopl_wrseq. Expected strobes are derived from
// the timing rules: ADDR two clocks after a push into an idle sequencer,
// DATA two clocks after the WAIT_ADDR-th tick following ADDR, IDLE two
// clocks after the WAIT_DATA-th tick following DATA, next ADDR one later.
module tb_jtopl_wrseq;

   localparam int WA   = 12;
   localparam int WD   = 84;
   localparam int NCYC = 16384;

   typedef struct {
      int         cyc;
      bit         is_data;
      logic [7:0] din;
   } strobe_t;

   typedef struct {
      int         cyc;
      logic [7:0] r;
      logic [7:0] v;
   } push_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cenop;
   logic       push;
   logic [7:0] push_reg;
   logic [7:0] push_val;
   logic       full, empty, ovf, busy, wr, wr_addr;
   logic [7:0] wr_din;

   logic       push_z;
   logic [7:0] push_reg_z;
   logic [7:0] push_val_z;
   logic       full_z, empty_z, ovf_z, busy_z, wr_z, wr_addr_z;
   logic [7:0] wr_din_z;

   int         cyc;
   int         n_cmp;
   int         n_fail;
   bit         cen_pat [NCYC];
   strobe_t    ev_q [$];
   push_t      push_q [$];
   logic [7:0] plan_r [$];
   logic [7:0] plan_v [$];

   always #5 clk = ~clk;

   jtopl_wrseq #(
      .DEPTH     (4),
      .WAIT_ADDR (WA),
      .WAIT_DATA (WD),
      .CW        (7)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cenop    (cenop),
      .push     (push),
      .push_reg (push_reg),
      .push_val (push_val),
      .full     (full),
      .empty    (empty),
      .ovf      (ovf),
      .busy     (busy),
      .wr       (wr),
      .wr_addr  (wr_addr),
      .wr_din   (wr_din)
   );

   jtopl_wrseq #(
      .DEPTH     (4),
      .WAIT_ADDR (0),
      .WAIT_DATA (0),
      .CW        (7)
   ) dut_z (
      .clk      (clk),
      .rst      (rst),
      .cenop    (cenop),
      .push     (push_z),
      .push_reg (push_reg_z),
      .push_val (push_val_z),
      .full     (full_z),
      .empty    (empty_z),
      .ovf      (ovf_z),
      .busy     (busy_z),
      .wr       (wr_z),
      .wr_addr  (wr_addr_z),
      .wr_din   (wr_din_z)
   );

   // Hard stop in case the sequence never completes.
   initial begin
      #(NCYC * 20);
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      check_output({tag, "_wr"},      {7'b0, wr},      8'h00);
      check_output({tag, "_wr_addr"}, {7'b0, wr_addr}, 8'h00);
      check_output({tag, "_wr_din"},  wr_din,          8'h00);
      check_output({tag, "_ovf"},     {7'b0, ovf},     8'h00);
      check_output({tag, "_full"},    {7'b0, full},    8'h00);
      check_output({tag, "_empty"},   {7'b0, empty},   8'h01);
      check_output({tag, "_busy"},    {7'b0, busy},    8'h00);
   endtask

   // Cycle in which the w-th cenop tick after cycle 'start' lands, plus two.
   function automatic int settle(input int start, input int w);
      int c = start;
      int n = 0;
      while (n < w && c < NCYC - 1) begin
         c++;
         if (cen_pat[c]) n++;
      end
      return c + 2;
   endfunction

   // Queues the expected strobes for the planned pairs; returns IDLE cycle.
   function automatic int plan_pairs(input int first_addr);
      int a    = first_addr;
      int d;
      int idle = first_addr;
      for (int k = 0; k < plan_r.size(); k++) begin
         ev_q.push_back('{a, 1'b0, plan_r[k]});
         d = settle(a, WA);
         ev_q.push_back('{d, 1'b1, plan_v[k]});
         idle = settle(d, WD);
         a = idle + 1;
      end
      plan_r.delete();
      plan_v.delete();
      return idle;
   endfunction

   function automatic void fill_cen(input int lo, input int hi, input int mode);
      for (int i = lo; i <= hi && i < NCYC; i++) begin
         case (mode)
            0:       cen_pat[i] = 1'b0;
            1:       cen_pat[i] = (i % 4 == 0);
            default: cen_pat[i] = ($urandom_range(0, 2) == 0);
         endcase
      end
   endfunction

   task automatic apply_stimulus();
      push_t p;
      cenop = (cyc < NCYC) ? cen_pat[cyc] : 1'b1;
      push  = 1'b0;
      if (push_q.size() > 0 && push_q[0].cyc == cyc) begin
         p        = push_q.pop_front();
         push     = 1'b1;
         push_reg = p.r;
         push_val = p.v;
      end
   endtask

   // One clock: compare the strobe outputs with the schedule, then drive.
   task automatic cycle();
      strobe_t e;
      bit      exp_wr;
      @(negedge clk);
      cyc++;
      exp_wr = (ev_q.size() > 0 && ev_q[0].cyc == cyc);
      check_output("wr", {7'b0, wr}, {7'b0, exp_wr});
      if (exp_wr) begin
         e = ev_q.pop_front();
         check_output("wr_addr", {7'b0, wr_addr}, {7'b0, e.is_data});
         check_output("wr_din", wr_din, e.din);
      end
      apply_stimulus();
   endtask

   task automatic run_to(input int target);
      while (cyc < target) cycle();
   endtask

   // Directed sequence of scenarios with randomized data and cenop patterns.
   initial begin
      int         t, a, d, d0, idle;
      logic [7:0] rr [6];
      logic [7:0] vv [6];

      rst = 1'b1; cenop = 1'b0; push = 1'b0; push_reg = 8'h00; push_val = 8'h00;
      push_z = 1'b0; push_reg_z = 8'h00; push_val_z = 8'h00;
      n_cmp = 0; n_fail = 0; cyc = 0;
      fill_cen(0, NCYC - 1, 1);

      $display("[TB] reset");
      cycle(); cycle(); cycle();
      check_reset("rst_hold");
      rst = 1'b0;
      cycle();
      check_reset("rst_rel");

      $display("[TB] single pair, cenop every 4 clk");
      t = cyc + 1;
      push_q.push_back('{t, 8'h20, 8'h01});
      plan_r.push_back(8'h20); plan_v.push_back(8'h01);
      idle = plan_pairs(t + 2);
      run_to(t + 1);
      check_output("t1_busy_rise", {7'b0, busy}, 8'h01);
      check_output("t1_empty_fall", {7'b0, empty}, 8'h00);
      run_to(idle - 1);
      check_output("t1_busy_hold", {7'b0, busy}, 8'h01);
      run_to(idle);
      check_output("t1_busy_fall", {7'b0, busy}, 8'h00);
      check_output("t1_empty_end", {7'b0, empty}, 8'h01);
      check_output("t1_ovf", {7'b0, ovf}, 8'h00);

      $display("[TB] burst of pairs, overflow, drop while popping");
      t = cyc + 1;
      fill_cen(t, t + 4000, 2);
      for (int k = 0; k < 6; k++) begin
         rr[k] = 8'($urandom);
         vv[k] = 8'($urandom);
      end
      for (int k = 0; k < 4; k++) begin
         push_q.push_back('{t + k, rr[k], vv[k]});
         plan_r.push_back(rr[k]); plan_v.push_back(vv[k]);
      end
      push_q.push_back('{t + 4, 8'hEE, 8'hEE});
      d0 = settle(t + 2, WA);
      push_q.push_back('{d0, 8'hDD, 8'hDD});
      push_q.push_back('{d0 + 1, rr[5], vv[5]});
      plan_r.push_back(rr[5]); plan_v.push_back(vv[5]);
      idle = plan_pairs(t + 2);
      run_to(t + 4);
      check_output("t2_full", {7'b0, full}, 8'h01);
      check_output("t2_ovf_pre", {7'b0, ovf}, 8'h00);
      run_to(t + 5);
      check_output("t2_ovf_set", {7'b0, ovf}, 8'h01);
      check_output("t2_full_hold", {7'b0, full}, 8'h01);
      run_to(d0 + 1);
      check_output("t2_full_after_pop", {7'b0, full}, 8'h00);
      run_to(d0 + 2);
      check_output("t2_full_refill", {7'b0, full}, 8'h01);
      run_to(idle);
      check_output("t2_empty_end", {7'b0, empty}, 8'h01);
      check_output("t2_busy_end", {7'b0, busy}, 8'h00);
      check_output("t2_ovf_sticky", {7'b0, ovf}, 8'h01);

      $display("[TB] cenop stalled inside the address wait");
      t = cyc + 1;
      a = t + 2;
      fill_cen(t, a + 10, 1);
      fill_cen(a + 11, a + 1010, 0);
      fill_cen(a + 1011, a + 3000, 1);
      rr[0] = 8'($urandom); vv[0] = 8'($urandom);
      push_q.push_back('{t, rr[0], vv[0]});
      plan_r.push_back(rr[0]); plan_v.push_back(vv[0]);
      idle = plan_pairs(a);
      run_to(a + 1005);
      check_output("t3_busy_stall", {7'b0, busy}, 8'h01);
      check_output("t3_empty_stall", {7'b0, empty}, 8'h00);
      run_to(idle);
      check_output("t3_busy_end", {7'b0, busy}, 8'h00);

      $display("[TB] reset during data wait with entries queued");
      t = cyc + 1;
      fill_cen(t, t + 3000, 1);
      for (int k = 0; k < 3; k++) begin
         rr[k] = 8'($urandom); vv[k] = 8'($urandom);
         push_q.push_back('{t + k, rr[k], vv[k]});
      end
      a = t + 2;
      d = settle(a, WA);
      ev_q.push_back('{a, 1'b0, rr[0]});
      ev_q.push_back('{d, 1'b1, vv[0]});
      run_to(d + 5);
      check_output("t4_queued", {7'b0, empty}, 8'h00);
      rst = 1'b1;
      cycle();
      check_reset("t4_abort");
      rst = 1'b0;
      run_to(cyc + 500);
      check_output("t4_empty_after", {7'b0, empty}, 8'h01);
      check_output("t4_busy_after", {7'b0, busy}, 8'h00);

      $display("[TB] zero-wait build");
      t = cyc + 1;
      cycle();
      push_z = 1'b1; push_reg_z = 8'hBD; push_val_z = 8'h20;
      for (int k = 1; k <= 7; k++) begin
         cycle();
         push_z = 1'b0;
         check_output($sformatf("z_wr_%0d", k), {7'b0, wr_z}, {7'b0, (k == 2 || k == 4)});
         if (k == 2 || k == 4) begin
            check_output($sformatf("z_addr_%0d", k), {7'b0, wr_addr_z}, {7'b0, (k == 4)});
         end
         check_output($sformatf("z_din_%0d", k), wr_din_z, (k < 2) ? 8'h00 : (k < 4) ? 8'hBD : 8'h20);
         check_output($sformatf("z_busy_%0d", k), {7'b0, busy_z}, {7'b0, (k <= 5)});
      end
      check_output("z_empty_end", {7'b0, empty_z}, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
